alarm_controller: RTL and testbench

- Alarm stage directly downstream of the 24-hour time-of-day counter.
- Consumes the live hours/minutes/seconds values and that counter's once-per-second tick.
- Holds a user-set alarm time and runs a ring/snooze/dismiss state machine.
- Drives a ringing flag and a blinking LED toward the board outputs.

---
 rtl/alarm_controller.sv | 201 ++++++++++++++++++++
 tb/tb_alarm_controller.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_controller.sv
// Alarm stage behind the 24-hour time-of-day counter: stores an alarm time and runs ring/snooze/dismiss.
// Optional hourly chime is built only when ALARM_HOURLY_CHIME_EN is defined; otherwise chime is tied low.
module alarm_controller #(
    parameter int SNOOZE_MIN       = 5,
    parameter int RING_TIMEOUT_SEC = 60,
    parameter int BLINK_DIV        = 25000000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       sec_tick,
    input  logic [4:0] hours,
    input  logic [5:0] minutes,
    input  logic [5:0] seconds,
    input  logic       set_alarm,
    input  logic [4:0] alarm_hours_in,
    input  logic [5:0] alarm_min_in,
    input  logic       arm,
    input  logic       snooze,
    input  logic       dismiss,
    output logic [4:0] alarm_hours,
    output logic [5:0] alarm_minutes,
    output logic [1:0] state,
    output logic       ringing,
    output logic       snooze_active,
    output logic       alarm_led,
    output logic       chime
);

    localparam int SNOOZE_LOAD = SNOOZE_MIN * 60;
    localparam int SNOOZE_W    = (SNOOZE_LOAD > 0) ? $clog2(SNOOZE_LOAD + 1) : 1;
    localparam int RING_W      = (RING_TIMEOUT_SEC > 0) ? $clog2(RING_TIMEOUT_SEC + 1) : 1;
    localparam int BLINK_W     = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [SNOOZE_W-1:0] SNOOZE_LOAD_V = SNOOZE_W'(SNOOZE_LOAD);
    localparam logic [RING_W-1:0]   RING_LIMIT_V  = RING_W'(RING_TIMEOUT_SEC);
    localparam logic [BLINK_W-1:0]  BLINK_LAST_V  = BLINK_W'(BLINK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        RINGING = 2'd2,
        SNOOZE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [4:0]          alarm_hours_q, alarm_hours_d;
    logic [5:0]          alarm_minutes_q, alarm_minutes_d;
    logic [RING_W-1:0]   ring_cnt_q, ring_cnt_d;
    logic [RING_W-1:0]   ring_cnt_inc;
    logic [SNOOZE_W-1:0] snooze_cnt_q, snooze_cnt_d;
    logic [BLINK_W-1:0]  blink_cnt_q, blink_cnt_d;
    logic                alarm_led_q, alarm_led_d;
    logic                match_prev_q, match_prev_d;
    logic                match;
    logic                trigger;

    // Edge-detected match: one trigger per alarm minute, so a dismissed alarm cannot re-ring.
    assign match   = (hours == alarm_hours_q) && (minutes == alarm_minutes_q) && (seconds == 6'd0);
    assign trigger = match && !match_prev_q;
    assign ring_cnt_inc = ring_cnt_q + RING_W'(1);

    always_comb begin
        state_d         = state_q;
        alarm_hours_d   = alarm_hours_q;
        alarm_minutes_d = alarm_minutes_q;
        ring_cnt_d      = ring_cnt_q;
        snooze_cnt_d    = snooze_cnt_q;
        match_prev_d    = match;

        if (set_alarm) begin
            alarm_hours_d   = (alarm_hours_in >= 5'd24) ? alarm_hours_in - 5'd24 : alarm_hours_in;
            alarm_minutes_d = (alarm_min_in >= 6'd60) ? alarm_min_in - 6'd60 : alarm_min_in;
            state_d         = arm ? ARMED : IDLE;
        end else if (!arm) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = ARMED;
                end
                ARMED: begin
                    if (trigger) begin
                        state_d    = RINGING;
                        ring_cnt_d = '0;
                    end
                end
                RINGING: begin
                    if (dismiss) begin
                        state_d = ARMED;
                    end else if (snooze) begin
                        state_d      = SNOOZE;
                        snooze_cnt_d = SNOOZE_LOAD_V;
                    end else if (sec_tick) begin
                        ring_cnt_d = ring_cnt_inc;
                        if (ring_cnt_inc >= RING_LIMIT_V) begin
                            state_d = ARMED;
                        end
                    end
                end
                SNOOZE: begin
                    if (dismiss) begin
                        state_d = ARMED;
                    end else if (sec_tick) begin
                        // Count of 1 (or an empty load) expires now rather than wrapping.
                        if (snooze_cnt_q <= SNOOZE_W'(1)) begin
                            snooze_cnt_d = '0;
                            state_d      = RINGING;
                            ring_cnt_d   = '0;
                        end else begin
                            snooze_cnt_d = snooze_cnt_q - SNOOZE_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // LED restarts lit on every entry to RINGING and is forced dark everywhere else.
    always_comb begin
        blink_cnt_d = '0;
        alarm_led_d = 1'b0;
        if (state_d == RINGING) begin
            if (state_q != RINGING) begin
                alarm_led_d = 1'b1;
            end else if (blink_cnt_q >= BLINK_LAST_V) begin
                alarm_led_d = !alarm_led_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BLINK_W'(1);
                alarm_led_d = alarm_led_q;
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q         <= IDLE;
            alarm_hours_q   <= '0;
            alarm_minutes_q <= '0;
            ring_cnt_q      <= '0;
            snooze_cnt_q    <= '0;
            blink_cnt_q     <= '0;
            alarm_led_q     <= 1'b0;
            match_prev_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            alarm_hours_q   <= alarm_hours_d;
            alarm_minutes_q <= alarm_minutes_d;
            ring_cnt_q      <= ring_cnt_d;
            snooze_cnt_q    <= snooze_cnt_d;
            blink_cnt_q     <= blink_cnt_d;
            alarm_led_q     <= alarm_led_d;
            match_prev_q    <= match_prev_d;
        end
    end

`ifdef ALARM_HOURLY_CHIME_EN
    logic hour_top;
    logic hour_top_prev_q, hour_top_prev_d;
    logic chime_q, chime_d;

    assign hour_top = (minutes == 6'd0) && (seconds == 6'd0);

    // Set on the top-of-hour edge, cleared by the following second; ringing mutes it.
    always_comb begin
        hour_top_prev_d = hour_top;
        chime_d         = chime_q;
        if (state_q == RINGING) begin
            chime_d = 1'b0;
        end else if (hour_top && !hour_top_prev_q) begin
            chime_d = 1'b1;
        end else if (sec_tick) begin
            chime_d = 1'b0;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            hour_top_prev_q <= 1'b0;
            chime_q         <= 1'b0;
        end else begin
            hour_top_prev_q <= hour_top_prev_d;
            chime_q         <= chime_d;
        end
    end

    assign chime = chime_q;
`else
    assign chime = 1'b0;
`endif

    assign alarm_hours   = alarm_hours_q;
    assign alarm_minutes = alarm_minutes_q;
    assign state         = state_q;
    assign ringing       = (state_q == RINGING);
    assign snooze_active = (state_q == SNOOZE);
    assign alarm_led     = alarm_led_q;

endmodule

// File: tb/tb_alarm_controller.sv
// Directed bench for alarm_controller: a vector table for load/trigger/blink plus hand sequences
// for re-ring suppression, snooze, timeout, arm drop, reset and the hourly chime.
module tb_alarm_controller;

    logic       CLOCK_50;
    logic       reset;
    logic       sec_tick;
    logic [4:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic       set_alarm;
    logic [4:0] alarm_hours_in;
    logic [5:0] alarm_min_in;
    logic       arm;
    logic       snooze;
    logic       dismiss;
    logic [4:0] alarm_hours;
    logic [5:0] alarm_minutes;
    logic [1:0] state;
    logic       ringing;
    logic       snooze_active;
    logic       alarm_led;
    logic       chime;

    int tests_run;
    int tests_failed;

`ifdef ALARM_HOURLY_CHIME_EN
    localparam logic CHIME_ON = 1'b1;
`else
    localparam logic CHIME_ON = 1'b0;
`endif

    alarm_controller #(
        .SNOOZE_MIN      (1),
        .RING_TIMEOUT_SEC(5),
        .BLINK_DIV       (4)
    ) dut (
        .CLOCK_50      (CLOCK_50),
        .reset         (reset),
        .sec_tick      (sec_tick),
        .hours         (hours),
        .minutes       (minutes),
        .seconds       (seconds),
        .set_alarm     (set_alarm),
        .alarm_hours_in(alarm_hours_in),
        .alarm_min_in  (alarm_min_in),
        .arm           (arm),
        .snooze        (snooze),
        .dismiss       (dismiss),
        .alarm_hours   (alarm_hours),
        .alarm_minutes (alarm_minutes),
        .state         (state),
        .ringing       (ringing),
        .snooze_active (snooze_active),
        .alarm_led     (alarm_led),
        .chime         (chime)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        logic       set_alarm;
        logic [4:0] ah_in;
        logic [5:0] am_in;
        logic       arm;
        logic       dismiss;
        logic [4:0] h;
        logic [5:0] m;
        logic [5:0] s;
        logic [4:0] exp_ah;
        logic [5:0] exp_am;
        logic [1:0] exp_state;
        logic       exp_led;
    } vec_t;

    vec_t vecs[14];

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic set_time(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
        hours   = h;
        minutes = m;
        seconds = s;
    endtask

    task automatic pulse_tick();
        sec_tick = 1'b1;
        tick();
        sec_tick = 1'b0;
        tick();
    endtask

    // Walks ARMED into RINGING by forcing a fresh 07:30:00 edge.
    task automatic ring_now();
        set_time(5'd7, 6'd30, 6'd1);
        tick();
        set_time(5'd7, 6'd30, 6'd0);
        tick();
    endtask

    task automatic set_vec(input int i, input logic sa, input logic [4:0] ahi, input logic [5:0] ami,
                           input logic a, input logic d, input logic [4:0] h, input logic [5:0] m,
                           input logic [5:0] s, input logic [4:0] eah, input logic [5:0] eam,
                           input logic [1:0] est, input logic eled);
        vecs[i] = '{sa, ahi, ami, a, d, h, m, s, eah, eam, est, eled};
    endtask

    initial begin
        tests_run      = 0;
        tests_failed   = 0;
        reset          = 1'b1;
        sec_tick       = 1'b0;
        set_alarm      = 1'b0;
        alarm_hours_in = '0;
        alarm_min_in   = '0;
        arm            = 1'b0;
        snooze         = 1'b0;
        dismiss        = 1'b0;
        set_time(5'd12, 6'd0, 6'd10);

        // Load/modulo, trigger at 07:30:00, then blink: lit 4 cycles, dark 4, lit again; dismiss.
        set_vec(0,  1, 25, 61, 0, 0, 12,  0, 10,  1,  1, 0, 0);
        set_vec(1,  1, 25, 61, 1, 0, 12,  0, 10,  1,  1, 1, 0);
        set_vec(2,  1,  7, 30, 1, 0,  7, 29, 59,  7, 30, 1, 0);
        set_vec(3,  0,  0,  0, 1, 0,  7, 29, 59,  7, 30, 1, 0);
        set_vec(4,  0,  0,  0, 1, 0,  7, 30,  0,  7, 30, 2, 1);
        set_vec(5,  0,  0,  0, 1, 0,  7, 30,  0,  7, 30, 2, 1);
        set_vec(6,  0,  0,  0, 1, 0,  7, 30,  0,  7, 30, 2, 1);
        set_vec(7,  0,  0,  0, 1, 0,  7, 30,  0,  7, 30, 2, 1);
        set_vec(8,  0,  0,  0, 1, 0,  7, 30,  0,  7, 30, 2, 0);
        set_vec(9,  0,  0,  0, 1, 0,  7, 30,  0,  7, 30, 2, 0);
        set_vec(10, 0,  0,  0, 1, 0,  7, 30,  0,  7, 30, 2, 0);
        set_vec(11, 0,  0,  0, 1, 0,  7, 30,  0,  7, 30, 2, 0);
        set_vec(12, 0,  0,  0, 1, 0,  7, 30,  0,  7, 30, 2, 1);
        set_vec(13, 0,  0,  0, 1, 1,  7, 30,  0,  7, 30, 1, 0);

        tick();
        tick();
        check("reset_state", state, 0);
        check("reset_alarm_hours", alarm_hours, 0);
        check("reset_alarm_minutes", alarm_minutes, 0);
        check("reset_ringing", ringing, 0);
        check("reset_snooze_active", snooze_active, 0);
        check("reset_led", alarm_led, 0);
        check("reset_chime", chime, 0);
        reset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            set_alarm      = vecs[i].set_alarm;
            alarm_hours_in = vecs[i].ah_in;
            alarm_min_in   = vecs[i].am_in;
            arm            = vecs[i].arm;
            dismiss        = vecs[i].dismiss;
            set_time(vecs[i].h, vecs[i].m, vecs[i].s);
            tick();
            check($sformatf("vec%0d_alarm_hours", i), alarm_hours, vecs[i].exp_ah);
            check($sformatf("vec%0d_alarm_minutes", i), alarm_minutes, vecs[i].exp_am);
            check($sformatf("vec%0d_state", i), state, vecs[i].exp_state);
            check($sformatf("vec%0d_led", i), alarm_led, vecs[i].exp_led);
            check($sformatf("vec%0d_ringing", i), ringing, vecs[i].exp_state == 2'd2);
            check($sformatf("vec%0d_snooze_active", i), snooze_active, vecs[i].exp_state == 2'd3);
            check($sformatf("vec%0d_chime", i), chime, 0);
        end
        set_alarm = 1'b0;
        dismiss   = 1'b0;

        // Still inside the alarm minute after dismiss: must not re-ring.
        for (int i = 0; i < 10; i++) begin
            tick();
            check("hold_minute_no_rering", state, 1);
        end

        // Next day's 07:30:00 rings again.
        set_time(5'd7, 6'd31, 6'd0);
        tick();
        set_time(5'd7, 6'd30, 6'd0);
        tick();
        check("next_day_ring", state, 2);

        snooze = 1'b1;
        tick();
        snooze = 1'b0;
        check("snooze_state", state, 3);
        check("snooze_active", snooze_active, 1);
        check("snooze_ringing_low", ringing, 0);
        check("snooze_led_low", alarm_led, 0);
        for (int i = 0; i < 59; i++) pulse_tick();
        check("snooze_59_ticks", state, 3);
        pulse_tick();
        check("snooze_expire_ring", state, 2);
        check("snooze_expire_led", alarm_led, 1);

        // Fresh ring_cnt after snooze: four ticks still ringing, fifth times out.
        for (int i = 0; i < 4; i++) pulse_tick();
        check("timeout_4_ticks", state, 2);
        pulse_tick();
        check("timeout_state", state, 1);
        check("timeout_led", alarm_led, 0);
        check("timeout_ringing", ringing, 0);

        ring_now();
        check("ring_again", state, 2);
        snooze  = 1'b1;
        dismiss = 1'b1;
        tick();
        snooze  = 1'b0;
        dismiss = 1'b0;
        check("dismiss_beats_snooze", state, 1);

        ring_now();
        snooze = 1'b1;
        tick();
        snooze = 1'b0;
        check("snooze_again", state, 3);
        dismiss = 1'b1;
        tick();
        dismiss = 1'b0;
        check("dismiss_in_snooze", state, 1);

        ring_now();
        snooze = 1'b1;
        tick();
        snooze = 1'b0;
        arm = 1'b0;
        tick();
        check("arm_drop_in_snooze", state, 0);
        check("arm_drop_snooze_active", snooze_active, 0);

        arm = 1'b1;
        tick();
        check("rearm", state, 1);
        ring_now();
        tick();
        tick();
        check("pre_reset_ringing", ringing, 1);
        reset = 1'b1;
        tick();
        check("midring_reset_state", state, 0);
        check("midring_reset_ringing", ringing, 0);
        check("midring_reset_led", alarm_led, 0);
        check("midring_reset_alarm_hours", alarm_hours, 0);
        check("midring_reset_alarm_minutes", alarm_minutes, 0);
        check("midring_reset_chime", chime, 0);
        reset = 1'b0;

        tick();
        set_time(5'd7, 6'd59, 6'd59);
        tick();
        check("chime_before_hour", chime, 0);
        set_time(5'd8, 6'd0, 6'd0);
        tick();
        check("chime_on_hour", chime, CHIME_ON);
        tick();
        check("chime_held", chime, CHIME_ON);
        sec_tick = 1'b1;
        tick();
        sec_tick = 1'b0;
        set_time(5'd8, 6'd0, 6'd1);
        check("chime_cleared", chime, 0);
        tick();
        check("chime_stays_low", chime, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
